// File: rtl/tone_synth_if.sv
`default_nettype none
// ============================================================================
//  Module      : tone_synth_if
//  Description : Key/octave/volume inputs and Pmod amplifier pins of the
//                keyboard tone generator, bundled as one interface.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tone_synth_if #(
    parameter int N_KEYS = 7
);
    logic [N_KEYS-1:0] keys;
    logic [2:0]        octave;
    logic [2:0]        volume;
    logic              AIN;
    logic              GAIN;
    logic              NC;
    logic              ACTIVE;
    logic              playing;

    // Controller side: drives the keyboard controls, observes the amplifier pins
    modport master (
        output keys, octave, volume,
        input  AIN, GAIN, NC, ACTIVE, playing
    );

    // Synthesiser side
    modport slave (
        input  keys, octave, volume,
        output AIN, GAIN, NC, ACTIVE, playing
    );
endinterface
`default_nettype wire

// File: rtl/tone_synth.sv
`default_nettype none
// ============================================================================
//  Module      : tone_synth
//  Description : Keyboard tone generator for the Pmod amplifier. A pressed
//                key picks a note, octave shifts it, an attack/sustain/
//                release envelope and a volume setting set the amplitude,
//                and the square wave is PWM-gated onto AIN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_synth #(
    parameter int CLK_HZ   = 100000000,
    parameter int N_KEYS   = 7,
    parameter int DIV_W    = 20,
    parameter int ENV_STEP = 4096,
    parameter bit GAIN_LOW = 1'b1
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    tone_synth_if.slave bus
);
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ATTACK  = 2'd1;
    localparam logic [1:0] c_SUSTAIN = 2'd2;
    localparam logic [1:0] c_RELEASE = 2'd3;

    localparam int c_SEL_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int c_ENV_W = (ENV_STEP > 1) ? $clog2(ENV_STEP) : 1;
    localparam logic [c_ENV_W-1:0] c_ENV_LAST = c_ENV_W'(ENV_STEP - 1);

    // Note frequencies C2..B2 in Hz; keys past the table reuse the top note
    function automatic int f_freq(input int idx);
        case (idx)
            0:       f_freq = 65;
            1:       f_freq = 73;
            2:       f_freq = 82;
            3:       f_freq = 87;
            4:       f_freq = 98;
            5:       f_freq = 110;
            default: f_freq = 123;
        endcase
    endfunction

    logic [N_KEYS-1:0]  r_keys_s1, r_keys_s2;
    logic [2:0]         r_oct_s1, r_oct_s2;
    logic [1:0]         r_state, w_state_nxt;
    logic [7:0]         r_level;
    logic [c_ENV_W-1:0] r_env_cnt;
    logic [DIV_W-1:0]   r_half_cnt;
    logic               r_wave;
    logic [7:0]         r_pwm_cnt;
    logic               r_ain;

    logic [DIV_W-1:0]   w_half_tab [N_KEYS];
    logic [c_SEL_W-1:0] w_sel;
    logic               w_any_key;
    logic [2:0]         w_oct_sat;
    logic [DIV_W-1:0]   w_shift;
    logic [DIV_W-1:0]   w_reload;
    logic               w_tick;
    logic [3:0]         w_vol1;
    logic [10:0]        w_prod;
    logic [7:0]         w_amp;

    // Half-period table folded to constants at elaboration
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_half
        localparam int c_F = f_freq(gi);
        assign w_half_tab[gi] = DIV_W'(CLK_HZ / (2 * c_F));
    end

    // Two-flop synchronisers for the asynchronous key and octave inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_keys_s1 <= '0;
            r_keys_s2 <= '0;
            r_oct_s1  <= '0;
            r_oct_s2  <= '0;
        end else begin
            r_keys_s1 <= bus.keys;
            r_keys_s2 <= r_keys_s1;
            r_oct_s1  <= bus.octave;
            r_oct_s2  <= r_oct_s1;
        end
    end

    // Lowest pressed key wins; divider is shifted by the saturated octave and
    // clamped to 1 so the reload value never underflows
    always_comb begin
        w_sel = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (r_keys_s2[i]) w_sel = c_SEL_W'(i);
        end
        w_any_key = |r_keys_s2;
        w_oct_sat = (r_oct_s2 > 3'd4) ? 3'd4 : r_oct_s2;
        w_shift   = w_half_tab[w_sel] >> w_oct_sat;
        w_reload  = (w_shift == '0) ? '0 : w_shift - 1'b1;
        w_tick    = (r_env_cnt == c_ENV_LAST);
    end

    // Envelope next state; a key event takes precedence over the level bound
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (w_any_key) w_state_nxt = c_ATTACK;
            c_ATTACK:  if (!w_any_key)                          w_state_nxt = c_RELEASE;
                       else if (w_tick && r_level >= 8'd254)    w_state_nxt = c_SUSTAIN;
            c_SUSTAIN: if (!w_any_key) w_state_nxt = c_RELEASE;
            default:   if (w_any_key)                           w_state_nxt = c_ATTACK;
                       else if (w_tick && r_level <= 8'd1)      w_state_nxt = c_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Envelope step counter and saturating level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_env_cnt <= '0;
            r_level   <= '0;
        end else begin
            if (w_state_nxt != r_state || w_tick)
                r_env_cnt <= '0;
            else if (r_state == c_ATTACK || r_state == c_RELEASE)
                r_env_cnt <= r_env_cnt + 1'b1;

            if (w_tick && r_state == c_ATTACK && w_any_key && r_level != 8'd255)
                r_level <= r_level + 8'd1;
            else if (w_tick && r_state == c_RELEASE && !w_any_key && r_level != 8'd0)
                r_level <= r_level - 8'd1;
        end
    end

    // Square wave: new divider only picked up at reload, frozen low in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half_cnt <= '0;
            r_wave     <= 1'b0;
        end else if (r_state == c_IDLE) begin
            if (w_state_nxt == c_ATTACK) begin
                r_half_cnt <= w_reload;
                r_wave     <= 1'b0;
            end
        end else if (w_state_nxt == c_IDLE) begin
            r_wave <= 1'b0;
        end else if (r_half_cnt == '0) begin
            r_wave     <= ~r_wave;
            r_half_cnt <= w_reload;
        end else begin
            r_half_cnt <= r_half_cnt - 1'b1;
        end
    end

    // Amplitude = level * (volume+1) / 8, at most 255
    always_comb begin
        w_vol1 = {1'b0, bus.volume} + 4'd1;
        w_prod = {3'b000, r_level} * {7'b0000000, w_vol1};
        w_amp  = 8'(w_prod >> 3);
    end

    // Free-running PWM ramp and registered gated output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
            r_ain     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            r_ain     <= r_wave & (r_pwm_cnt < w_amp);
        end
    end

    assign bus.AIN     = r_ain;
    assign bus.GAIN    = GAIN_LOW;
    assign bus.NC      = 1'b0;
    assign bus.ACTIVE  = (r_state != c_IDLE);
    assign bus.playing = (r_state == c_ATTACK) || (r_state == c_SUSTAIN);

endmodule
`default_nettype wire

// File: tb/tb_tone_synth.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_synth
//  Description : Directed bench for tone_synth at CLK_HZ=1300, ENV_STEP=1
//                (half periods 10,8,7,7,6,5,5 clocks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_synth;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tone_synth_if #(.N_KEYS(7)) bus ();

    tone_synth #(
        .CLK_HZ   (1300),
        .N_KEYS   (7),
        .DIV_W    (20),
        .ENV_STEP (1),
        .GAIN_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference PWM ramp: 8-bit free-running count of clocks since reset
    int pwm_model;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_model <= 0;
        else        pwm_model <= (pwm_model + 1) % 256;
    end

    typedef struct {
        logic [6:0] keys;
        logic [2:0] oct;
        int         first;
        int         half;
    } vec_t;
    vec_t vt [14];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.keys = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Count clocks until the wave output flips; -1 if it never does
    task automatic wait_toggle(output int n);
        logic w0;
        bit   found;
        w0    = dut.r_wave;
        n     = -1;
        found = 0;
        for (int c = 1; c <= 64 && !found; c++) begin
            @(negedge clk);
            if (dut.r_wave != w0) begin
                n     = c;
                found = 1;
            end
        end
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string name);
        bit found;
        found = 0;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge clk);
            if (dut.r_state == st) found = 1;
        end
        check(name, int'(found), 1);
    endtask

    initial begin
        int  n;
        int  bad;
        bit  found;
        logic pw;
        int  pp;
        int  exp_ain;

        // first toggle = 3 sync/FSM clocks + one half period
        vt[0]  = '{7'b0000001, 3'd0, 13, 10};
        vt[1]  = '{7'b0000010, 3'd0, 11, 8};
        vt[2]  = '{7'b0000100, 3'd0, 10, 7};
        vt[3]  = '{7'b0001000, 3'd1, 6,  3};
        vt[4]  = '{7'b0010000, 3'd1, 6,  3};
        vt[5]  = '{7'b0100000, 3'd2, 4,  1};
        vt[6]  = '{7'b1000000, 3'd0, 8,  5};
        vt[7]  = '{7'b0000011, 3'd0, 13, 10};
        vt[8]  = '{7'b1010100, 3'd0, 10, 7};
        vt[9]  = '{7'b0100000, 3'd7, 4,  1};
        vt[10] = '{7'b0000001, 3'd4, 4,  1};
        vt[11] = '{7'b0000001, 3'd3, 4,  1};
        vt[12] = '{7'b0000001, 3'd2, 5,  2};
        vt[13] = '{7'b1000000, 3'd1, 5,  2};

        bus.keys   = '0;
        bus.octave = 3'd0;
        bus.volume = 3'd7;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_AIN",     int'(bus.AIN), 0);
        check("rst_ACTIVE",  int'(bus.ACTIVE), 0);
        check("rst_playing", int'(bus.playing), 0);
        check("rst_state",   int'(dut.r_state), 0);
        check("GAIN",        int'(bus.GAIN), 1);
        check("NC",          int'(bus.NC), 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.AIN || bus.ACTIVE || bus.playing || !bus.GAIN || bus.NC) bad++;
        end
        check("idle_quiet_100", bad, 0);

        // ---- key C: latency, attack to 255 ----
        bus.keys = 7'b0000001;
        @(negedge clk); check("lat_clk1_ACTIVE", int'(bus.ACTIVE), 0);
        @(negedge clk); check("lat_clk2_ACTIVE", int'(bus.ACTIVE), 0);
        @(negedge clk); check("lat_clk3_ACTIVE", int'(bus.ACTIVE), 1);
        check("lat_clk3_playing", int'(bus.playing), 1);
        check("attack_start_level", int'(dut.r_level), 0);
        repeat (254) @(negedge clk);
        check("attack_254_level", int'(dut.r_level), 254);
        check("attack_254_state", int'(dut.r_state), 1);
        @(negedge clk);
        check("attack_255_level", int'(dut.r_level), 255);
        check("sustain_state", int'(dut.r_state), 2);
        check("amp_vol7", int'(dut.w_amp), 255);
        wait_toggle(n);
        wait_toggle(n); check("sustain_half_C", n, 10);

        // ---- priority and mid-half note change ----
        bus.keys = 7'b0000011;
        wait_toggle(n);
        wait_toggle(n); check("prio_half_a", n, 10);
        wait_toggle(n); check("prio_half_b", n, 10);
        repeat (3) @(negedge clk);
        bus.keys = 7'b0000010;
        wait_toggle(n); check("change_complete_half", n, 7);
        wait_toggle(n); check("change_new_half", n, 8);

        // ---- release, re-press at 100, full release ----
        bus.keys = '0;
        found = 0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (dut.r_level == 8'd102) found = 1;
        end
        check("release_reach_102", int'(found), 1);
        bus.keys = 7'b0000001;
        @(negedge clk); check("rel_level_101", int'(dut.r_level), 101);
        @(negedge clk); check("rel_level_100", int'(dut.r_level), 100);
        check("rel_state_still_release", int'(dut.r_state), 3);
        @(negedge clk); check("repress_state", int'(dut.r_state), 1);
        check("repress_level", int'(dut.r_level), 100);
        @(negedge clk); check("resume_level", int'(dut.r_level), 101);
        wait_state(2'd2, 400, "back_to_sustain");
        bus.keys = '0;
        n = -1;
        for (int c = 1; c <= 400 && n < 0; c++) begin
            @(negedge clk);
            if (!bus.ACTIVE) n = c;
        end
        check("full_release_clks", n, 258);
        check("idle_level", int'(dut.r_level), 0);
        check("idle_wave", int'(dut.r_wave), 0);
        @(negedge clk);
        check("idle_AIN", int'(bus.AIN), 0);
        check("idle_playing", int'(bus.playing), 0);

        // ---- note/octave table ----
        for (int i = 0; i < 14; i++) begin
            do_reset();
            bus.keys   = vt[i].keys;
            bus.octave = vt[i].oct;
            wait_toggle(n); check($sformatf("tbl%0d_first", i), n, vt[i].first);
            wait_toggle(n); check($sformatf("tbl%0d_half", i), n, vt[i].half);
        end

        // ---- low volume PWM gating, then async reset mid-note ----
        do_reset();
        bus.octave = 3'd0;
        bus.volume = 3'd0;
        bus.keys   = 7'b0000001;
        wait_state(2'd2, 600, "vol0_sustain");
        check("amp_vol0", int'(dut.w_amp), 31);
        bad = 0;
        repeat (256) begin
            pw = dut.r_wave;
            pp = pwm_model;
            @(negedge clk);
            exp_ain = (pw && pp < 31) ? 1 : 0;
            if (int'(bus.AIN) != exp_ain) bad++;
        end
        check("pwm_gate_256", bad, 0);
        bus.volume = 3'd3;
        #1 check("amp_vol3", int'(dut.w_amp), 127);
        bus.volume = 3'd0;
        found = 0;
        for (int c = 0; c < 600 && !found; c++) begin
            @(negedge clk);
            if (bus.AIN) found = 1;
        end
        check("AIN_seen_high", int'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_AIN", int'(bus.AIN), 0);
        check("async_rst_ACTIVE", int'(bus.ACTIVE), 0);
        check("async_rst_playing", int'(bus.playing), 0);
        check("async_rst_state", int'(dut.r_state), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
